// File: rtl/router_pkg.sv
// Shared constants, types and small helpers for the 1x3 packet router.
package router_pkg;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_WIDTH = 9;
    localparam int PTR_W      = 5;
    localparam int HDR_BIT    = 8;
    localparam int CNT_W      = 6;

    typedef logic [FIFO_WIDTH-1:0] entry_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    function automatic logic is_header(input entry_t e);
        return e[HDR_BIT];
    endfunction

    // Header byte bits 7:2 carry the payload length; one extra slot covers parity.
    function automatic cnt_t pkt_count(input entry_t hdr);
        return cnt_t'(hdr[7:2]) + 6'd1;
    endfunction
endpackage

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Entries carry a header marker
// so the packet counter can blank dataout (Z) between packets.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int ADD_SIZE = PTR_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       soft_reset,
    input  logic       write_enb,
    input  logic       read_enb,
    input  logic       lfd_state,
    input  logic [7:0] datain,
    output logic       full,
    output logic       empty,
    output logic [7:0] dataout
);
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADD_SIZE-1:0] wr_ptr;
    logic [ADD_SIZE-1:0] rd_ptr;
    cnt_t                count;
    logic [7:0]          data_q;
    logic                data_oe;
    logic                wr_fire;
    logic                rd_fire;
    entry_t              rd_entry;

    localparam logic [ADD_SIZE-1:0] PTR_ONE = {{(ADD_SIZE-1){1'b0}}, 1'b1};

    // The top pointer bit distinguishes full from empty when the addresses match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADD_SIZE-1] != rd_ptr[ADD_SIZE-1]) &&
                      (wr_ptr[ADD_SIZE-2:0] == rd_ptr[ADD_SIZE-2:0]);
    assign wr_fire  = write_enb && !full;
    assign rd_fire  = read_enb && !empty;
    assign rd_entry = mem[rd_ptr[ADD_SIZE-2:0]];
    assign dataout  = data_oe ? data_q : 8'hzz;

    // Storage, pointers, packet counter and the registered read port.
    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_q  <= 8'h00;
            data_oe <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (soft_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_q  <= 8'h00;
            data_oe <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                mem[wr_ptr[ADD_SIZE-2:0]] <= {lfd_state, datain};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (rd_fire && is_header(rd_entry)) begin
                count   <= pkt_count(rd_entry);
                data_q  <= rd_entry[7:0];
                data_oe <= 1'b1;
            end else if (count == 6'd0) begin
                data_oe <= 1'b0;
            end else if (rd_fire) begin
                count   <= count - 6'd1;
                data_q  <= rd_entry[7:0];
                data_oe <= 1'b1;
            end else begin
                data_oe <= data_oe;
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_router_fifo;
    logic       clk = 1'b0;
    logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
    logic [7:0] datain;
    wire        full, empty;
    wire  [7:0] dataout;

    int total = 0;
    int bad   = 0;

    router_fifo dut (
        .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .datain(datain), .full(full), .empty(empty), .dataout(dataout)
    );

    always #5 clk = ~clk;

    logic [8:0] q[$];
    int         m_cnt = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_z = 1'b0;
    bit         m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // A 2-state simulator resolves an undriven bus to 0, so accept either form of idle.
    task automatic chk_z(input string name, input logic [7:0] got);
        total++;
        if (!(got === 8'hzz || got === 8'h00)) begin
            bad++;
            $display("FAIL %s: got=%0h expected=zz at %0t", name, got, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: a plain queue plus the packet-length rule.
    always @(posedge clk) begin : model
        bit rd_ok, wr_ok;
        logic [8:0] head;
        head = 9'h000;
        if (resetn) begin
            q.delete();
            m_cnt = 0; m_data = 8'h00; m_z = 1'b0; m_valid = 1'b1;
        end else if (soft_reset) begin
            q.delete();
            m_cnt = 0; m_z = 1'b1;
        end else begin
            rd_ok = read_enb && (q.size() != 0);
            wr_ok = write_enb && (q.size() != 16);
            if (rd_ok) head = q.pop_front();
            if (wr_ok) q.push_back({lfd_state, datain});
            if (rd_ok && head[8]) begin
                m_cnt = (int'(head[7:2]) + 1) % 64;
                m_data = head[7:0]; m_z = 1'b0;
            end else if (m_cnt == 0) begin
                m_z = 1'b1;
            end else if (rd_ok) begin
                m_cnt = m_cnt - 1;
                m_data = head[7:0]; m_z = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == 16);
            if (m_z) chk_z("dataout_idle", dataout);
            else     chk("dataout", dataout, m_data);
        end
    end

    initial begin
        logic [7:0] pkt [5];
        logic [7:0] stored[$];
        int wp;
        pkt = '{8'h0C, 8'hA5, 8'h3C, 8'h7E, 8'h99};
        resetn = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; datain = 8'h00;
        tick();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_dataout", dataout, 8'h00);
        resetn = 1'b0;

        // Header 0C means three payload bytes plus parity.
        write_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lfd_state = (i == 0); datain = pkt[i];
            tick();
        end
        write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pkt_data", dataout, pkt[i]);
        end
        chk("pkt_empty", empty, 1'b1);
        tick();
        chk_z("pkt_idle", dataout);
        read_enb = 1'b0;

        // 17 writes into a 16-deep FIFO; header length keeps the whole burst visible.
        stored = {};
        write_enb = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lfd_state = (i == 0);
            datain = (i == 0) ? {6'd14, 2'($urandom)} : 8'($urandom);
            if (i < 16) stored.push_back(datain);
            tick();
            if (i == 14) chk("fill_not_full", full, 1'b0);
            if (i == 15) chk("fill_full", full, 1'b1);
        end
        write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("fill_data", dataout, stored[i]);
        end
        chk("fill_empty", empty, 1'b1);

        // Reading an empty FIFO must not underflow.
        tick();
        chk("under_empty", empty, 1'b1);
        chk("under_full", full, 1'b0);
        chk_z("under_idle", dataout);
        write_enb = 1'b1; datain = 8'h5A;
        tick();
        chk("rw_empty_write_kept", empty, 1'b0);
        write_enb = 1'b0;
        tick();
        chk("rw_empty_drained", empty, 1'b1);
        chk_z("rw_empty_nohdr", dataout);
        read_enb = 1'b0;

        // Full FIFO with simultaneous read and write: only the read happens.
        stored = {};
        write_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lfd_state = (i == 0);
            datain = (i == 0) ? {6'd15, 2'($urandom)} : 8'($urandom);
            stored.push_back(datain);
            tick();
        end
        lfd_state = 1'b0;
        chk("both_pre_full", full, 1'b1);
        read_enb = 1'b1; datain = 8'hEE;
        tick();
        chk("both_full_clear", full, 1'b0);
        chk("both_data", dataout, stored[0]);
        write_enb = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("both_drain", dataout, stored[i]);
        end
        chk("both_empty", empty, 1'b1);
        tick();
        chk("hold_mid_packet", dataout, stored[15]);
        read_enb = 1'b0;

        // Soft reset in the middle of a packet with eight entries stored.
        write_enb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            lfd_state = (i == 0);
            datain = (i == 0) ? 8'h1C : 8'($urandom);
            tick();
        end
        write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
        tick();
        chk("sr_hdr", dataout, 8'h1C);
        read_enb = 1'b0; soft_reset = 1'b1;
        tick();
        chk("sr_empty", empty, 1'b1);
        chk("sr_full", full, 1'b0);
        chk_z("sr_idle", dataout);
        soft_reset = 1'b0;
        pkt = '{8'h04, 8'h11, 8'h22, 8'h00, 8'h00};
        write_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lfd_state = (i == 0); datain = pkt[i];
            tick();
        end
        write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sr_next_pkt", dataout, pkt[i]);
        end
        tick();
        chk_z("sr_next_idle", dataout);

        // Randomized traffic; alternate phases bias towards full and towards empty.
        for (int c = 0; c < 3000; c++) begin
            wp = ((c / 300) % 2 == 1) ? 80 : 30;
            resetn     = ($urandom_range(0, 499) == 0);
            soft_reset = ($urandom_range(0, 199) == 0);
            write_enb  = ($urandom_range(0, 99) < wp);
            read_enb   = ($urandom_range(0, 99) < 50);
            lfd_state  = ($urandom_range(0, 7) == 0);
            datain     = 8'($urandom);
            tick();
        end
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
